prim_secded_39_32_rsp: RTL and testbench

PRIM_SECDED_39_32_RSP -- requirements
Module: prim_secded_39_32_rsp

---
 rtl/prim_secded_39_32_rsp.sv | 115 +++++++++++
 tb/tb_prim_secded_39_32_rsp.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prim_secded_39_32_rsp.sv
// prim_secded_39_32_rsp: SECDED decoder response stage with 2-entry skid FIFO, error counters and first-syndrome capture.
// Define PRIM_SECDED_SCRUB_EN to add the scrub write-back request port (scrub_req_o/scrub_data_o/scrub_ack_i).
module prim_secded_39_32_rsp #(
   parameter int CntW  = 16,
   parameter int Depth = 2
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            in_valid_i,
   output logic            in_ready_o,
   input  logic [31:0]     in_data_i,
   input  logic [6:0]      in_syndrome_i,
   input  logic [1:0]      in_err_i,
   output logic            out_valid_o,
   input  logic            out_ready_i,
   output logic [31:0]     out_data_o,
   output logic            out_err_o,
   output logic            alert_o,
   output logic [CntW-1:0] corr_cnt_o,
   output logic [CntW-1:0] uncorr_cnt_o,
   output logic [6:0]      first_syn_o,
   output logic            first_vld_o,
`ifdef PRIM_SECDED_SCRUB_EN
   output logic            scrub_req_o,
   output logic [31:0]     scrub_data_o,
   input  logic            scrub_ack_i,
`endif
   input  logic            cnt_clr_i
);
   logic [1:0] cnt_q, cnt_d, wpos;
   logic [32:0] ent0_q, ent1_q, ent0_d, ent1_d, wr_ent;
   logic valid_q, ready_q, alert_q, first_vld_q;
   logic [6:0] first_syn_q;
   logic [CntW-1:0] corr_q, uncorr_q;
   logic push, pop, is_uncorr, is_corr;

   // Entries hold {err, data}; entry 0 is always the head, so a pop shifts entry 1 down.
   always_comb begin
      push = in_valid_i & ready_q;
      pop = valid_q & out_ready_i;
      is_uncorr = push & in_err_i[1];
      is_corr = push & (in_err_i == 2'b01);
      wr_ent = {in_err_i[1], in_err_i[1] ? 32'h0 : in_data_i};
      cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
      wpos = cnt_q - {1'b0, pop};
      ent0_d = (push && wpos == 2'd0) ? wr_ent : pop ? ent1_q : ent0_q;
      ent1_d = (push && wpos == 2'd1) ? wr_ent : ent1_q;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         cnt_q <= '0;
         valid_q <= 1'b0;
         ready_q <= 1'b0;
         ent0_q <= '0;
         ent1_q <= '0;
         alert_q <= 1'b0;
         corr_q <= '0;
         uncorr_q <= '0;
         first_vld_q <= 1'b0;
         first_syn_q <= '0;
      end else begin
         cnt_q <= cnt_d;
         valid_q <= cnt_d != 2'd0;
         ready_q <= int'(cnt_d) < Depth;
         ent0_q <= ent0_d;
         ent1_q <= ent1_d;
         alert_q <= is_uncorr;
         if (cnt_clr_i) begin
            corr_q <= '0;
            uncorr_q <= '0;
            first_vld_q <= 1'b0;
            first_syn_q <= '0;
         end else begin
            if (is_corr && corr_q != '1) corr_q <= corr_q + CntW'(1);
            if (is_uncorr && uncorr_q != '1) uncorr_q <= uncorr_q + CntW'(1);
            if (push && in_syndrome_i != 7'h0 && !first_vld_q) begin
               first_vld_q <= 1'b1;
               first_syn_q <= in_syndrome_i;
            end
         end
      end
   end

`ifdef PRIM_SECDED_SCRUB_EN
   logic scrub_req_q;
   logic [31:0] scrub_data_q;

   // A pending request blocks new captures; extra correctable words are only counted.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         scrub_req_q <= 1'b0;
         scrub_data_q <= '0;
      end else if (scrub_req_q) begin
         scrub_req_q <= !scrub_ack_i;
      end else if (is_corr) begin
         scrub_req_q <= 1'b1;
         scrub_data_q <= in_data_i;
      end
   end

   assign scrub_req_o = scrub_req_q;
   assign scrub_data_o = scrub_data_q;
`endif

   assign in_ready_o = ready_q;
   assign out_valid_o = valid_q;
   assign out_err_o = ent0_q[32];
   assign out_data_o = ent0_q[31:0];
   assign alert_o = alert_q;
   assign corr_cnt_o = corr_q;
   assign uncorr_cnt_o = uncorr_q;
   assign first_syn_o = first_syn_q;
   assign first_vld_o = first_vld_q;
endmodule

// File: tb/tb_prim_secded_39_32_rsp.sv
// tb_prim_secded_39_32_rsp: scenario tasks plus a response scoreboard for prim_secded_39_32_rsp.
module tb_prim_secded_39_32_rsp;
   localparam int CNTW = 8;
   logic clk_i = 1'b0;
   logic rst_ni = 1'b0;
   logic in_valid_i = 1'b0;
   logic [31:0] in_data_i = '0;
   logic [6:0] in_syndrome_i = '0;
   logic [1:0] in_err_i = '0;
   logic out_ready_i = 1'b0;
   logic cnt_clr_i = 1'b0;
   logic in_ready_o, out_valid_o, out_err_o, alert_o, first_vld_o;
   logic [31:0] out_data_o;
   logic [CNTW-1:0] corr_cnt_o, uncorr_cnt_o;
   logic [6:0] first_syn_o;
`ifdef PRIM_SECDED_SCRUB_EN
   logic scrub_req_o;
   logic [31:0] scrub_data_o;
   logic scrub_ack_i = 1'b0;
`endif
   int errors = 0;
   int checks = 0;
   logic [32:0] sb[$];
   logic [32:0] exp_ent;

   prim_secded_39_32_rsp #(.CntW(CNTW), .Depth(2)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i),
      .in_syndrome_i(in_syndrome_i), .in_err_i(in_err_i),
      .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
      .out_err_o(out_err_o), .alert_o(alert_o),
      .corr_cnt_o(corr_cnt_o), .uncorr_cnt_o(uncorr_cnt_o),
      .first_syn_o(first_syn_o), .first_vld_o(first_vld_o),
`ifdef PRIM_SECDED_SCRUB_EN
      .scrub_req_o(scrub_req_o), .scrub_data_o(scrub_data_o), .scrub_ack_i(scrub_ack_i),
`endif
      .cnt_clr_i(cnt_clr_i)
   );

   always #5 clk_i = ~clk_i;

   // Scoreboard: expectations pushed on accept, compared in order on each response handshake.
   always @(negedge clk_i) begin
      if (!rst_ni) begin
         sb.delete();
      end else begin
         if (out_valid_o && out_ready_i) begin
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL resp_order: unexpected response err=%b data=%h, none expected", out_err_o, out_data_o);
            end else begin
               exp_ent = sb.pop_front();
               if ({out_err_o, out_data_o} !== exp_ent) begin
                  errors++;
                  $display("FAIL resp_order: got err=%b data=%h, expected err=%b data=%h", out_err_o, out_data_o, exp_ent[32], exp_ent[31:0]);
               end
            end
         end
         if (in_valid_i && in_ready_o) sb.push_back({in_err_i[1], in_err_i[1] ? 32'h0 : in_data_i});
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1);
   end

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] d, input logic [1:0] e, input logic [6:0] s);
      in_valid_i = v;
      in_data_i = d;
      in_err_i = e;
      in_syndrome_i = s;
   endtask

   task automatic test_reset();
      rst_ni = 1'b0;
      out_ready_i = 1'b1;
      drive(1'b1, 32'hFFFF_FFFF, 2'b10, 7'h7F);
      repeat (3) step();
      checks++;
      if ({in_ready_o, out_valid_o, out_err_o, alert_o, first_vld_o} !== 5'b0) begin
         errors++;
         $display("FAIL reset_flags: ready/valid/err/alert/fvld=%b expected 00000", {in_ready_o, out_valid_o, out_err_o, alert_o, first_vld_o});
      end
      checks++;
      if (out_data_o !== 32'h0 || corr_cnt_o !== '0 || uncorr_cnt_o !== '0 || first_syn_o !== 7'h0) begin
         errors++;
         $display("FAIL reset_values: data=%h corr=%h uncorr=%h syn=%h expected all 0", out_data_o, corr_cnt_o, uncorr_cnt_o, first_syn_o);
      end
      drive(1'b0, '0, 2'b00, 7'h0);
      rst_ni = 1'b1;
      step();
      checks++;
      if (in_ready_o !== 1'b1 || out_valid_o !== 1'b0) begin
         errors++;
         $display("FAIL reset_release: ready=%b valid=%b expected ready=1 valid=0", in_ready_o, out_valid_o);
      end
   endtask

   task automatic test_reset_midflight();
      out_ready_i = 1'b0;
      drive(1'b1, 32'hAAAA_0001, 2'b00, 7'h0);
      step();
      drive(1'b1, 32'hAAAA_0002, 2'b00, 7'h0);
      step();
      drive(1'b0, '0, 2'b00, 7'h0);
      checks++;
      if (out_valid_o !== 1'b1 || in_ready_o !== 1'b0) begin
         errors++;
         $display("FAIL mid_full: valid=%b ready=%b expected valid=1 ready=0", out_valid_o, in_ready_o);
      end
      rst_ni = 1'b0;
      step();
      rst_ni = 1'b1;
      out_ready_i = 1'b1;
      step();
      step();
      checks++;
      if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1) begin
         errors++;
         $display("FAIL mid_discard: valid=%b ready=%b expected valid=0 ready=1", out_valid_o, in_ready_o);
      end
   endtask

   task automatic test_stream();
      out_ready_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 32'h1000_0000 + i, 2'b00, 7'h0);
         step();
         checks++;
         if (out_valid_o !== 1'b1 || out_data_o !== 32'h1000_0000 + i || out_err_o !== 1'b0) begin
            errors++;
            $display("FAIL stream_latency%0d: valid=%b data=%h expected valid=1 data=%h", i, out_valid_o, out_data_o, 32'h1000_0000 + i);
         end
      end
      drive(1'b0, '0, 2'b00, 7'h0);
      step();
      checks++;
      if (out_valid_o !== 1'b0 || corr_cnt_o !== '0 || uncorr_cnt_o !== '0 || first_vld_o !== 1'b0) begin
         errors++;
         $display("FAIL stream_idle: valid=%b corr=%h uncorr=%h fvld=%b expected 0", out_valid_o, corr_cnt_o, uncorr_cnt_o, first_vld_o);
      end
   endtask

   task automatic test_backpressure();
      out_ready_i = 1'b0;
      drive(1'b1, 32'hB000_0001, 2'b00, 7'h0);
      step();
      drive(1'b1, 32'hB000_0002, 2'b00, 7'h0);
      step();
      drive(1'b1, 32'hB000_0003, 2'b00, 7'h0);
      step();
      step();
      checks++;
      if (in_ready_o !== 1'b0 || out_valid_o !== 1'b1 || out_data_o !== 32'hB000_0001) begin
         errors++;
         $display("FAIL bp_hold: ready=%b valid=%b data=%h expected ready=0 valid=1 data=b0000001", in_ready_o, out_valid_o, out_data_o);
      end
      out_ready_i = 1'b1;
      step();
      checks++;
      if (out_data_o !== 32'hB000_0002 || in_ready_o !== 1'b1) begin
         errors++;
         $display("FAIL bp_release: data=%h ready=%b expected data=b0000002 ready=1", out_data_o, in_ready_o);
      end
      step();
      drive(1'b0, '0, 2'b00, 7'h0);
      checks++;
      if (out_data_o !== 32'hB000_0003 || out_valid_o !== 1'b1) begin
         errors++;
         $display("FAIL bp_third: data=%h valid=%b expected data=b0000003 valid=1", out_data_o, out_valid_o);
      end
      step();
   endtask

   task automatic test_uncorr();
      out_ready_i = 1'b1;
      drive(1'b1, 32'h1234_5678, 2'b10, 7'h07);
      step();
      drive(1'b0, '0, 2'b00, 7'h0);
      checks++;
      if (out_valid_o !== 1'b1 || out_err_o !== 1'b1 || out_data_o !== 32'h0 || alert_o !== 1'b1) begin
         errors++;
         $display("FAIL uncorr_resp: valid=%b err=%b data=%h alert=%b expected 1 1 0 1", out_valid_o, out_err_o, out_data_o, alert_o);
      end
      checks++;
      if (uncorr_cnt_o !== 8'd1 || corr_cnt_o !== 8'd0 || first_vld_o !== 1'b1 || first_syn_o !== 7'h07) begin
         errors++;
         $display("FAIL uncorr_cnt: uncorr=%0d corr=%0d fvld=%b syn=%h expected 1 0 1 07", uncorr_cnt_o, corr_cnt_o, first_vld_o, first_syn_o);
      end
      step();
      checks++;
      if (alert_o !== 1'b0) begin
         errors++;
         $display("FAIL alert_pulse: alert=%b expected 0 one cycle later", alert_o);
      end
      drive(1'b1, 32'h5555_AAAA, 2'b11, 7'h55);
      step();
      drive(1'b0, '0, 2'b00, 7'h0);
      checks++;
      if (out_err_o !== 1'b1 || out_data_o !== 32'h0 || uncorr_cnt_o !== 8'd2 || corr_cnt_o !== 8'd0 || first_syn_o !== 7'h07) begin
         errors++;
         $display("FAIL err11: err=%b data=%h uncorr=%0d corr=%0d syn=%h expected 1 0 2 0 07", out_err_o, out_data_o, uncorr_cnt_o, corr_cnt_o, first_syn_o);
      end
      step();
   endtask

   task automatic test_clear();
      out_ready_i = 1'b1;
      drive(1'b1, 32'hC000_0001, 2'b01, 7'h03);
      step();
      checks++;
      if (corr_cnt_o !== 8'd1 || first_syn_o !== 7'h07) begin
         errors++;
         $display("FAIL corr_inc: corr=%0d syn=%h expected 1 07", corr_cnt_o, first_syn_o);
      end
      drive(1'b1, 32'hC000_0002, 2'b01, 7'h03);
      cnt_clr_i = 1'b1;
      step();
      cnt_clr_i = 1'b0;
      checks++;
      if (corr_cnt_o !== 8'd0 || uncorr_cnt_o !== 8'd0 || first_vld_o !== 1'b0) begin
         errors++;
         $display("FAIL clr_priority: corr=%0d uncorr=%0d fvld=%b expected 0 0 0", corr_cnt_o, uncorr_cnt_o, first_vld_o);
      end
      drive(1'b1, 32'hC000_0003, 2'b01, 7'h05);
      step();
      drive(1'b0, '0, 2'b00, 7'h0);
      checks++;
      if (corr_cnt_o !== 8'd1 || first_vld_o !== 1'b1 || first_syn_o !== 7'h05) begin
         errors++;
         $display("FAIL clr_recapture: corr=%0d fvld=%b syn=%h expected 1 1 05", corr_cnt_o, first_vld_o, first_syn_o);
      end
      step();
   endtask

   task automatic test_saturate();
      out_ready_i = 1'b1;
      cnt_clr_i = 1'b1;
      step();
      cnt_clr_i = 1'b0;
      for (int i = 0; i < (1 << CNTW) - 1; i++) begin
         drive(1'b1, 32'h5A00_0000 + i, 2'b01, 7'h11);
         step();
      end
      checks++;
      if (corr_cnt_o !== 8'hFF) begin
         errors++;
         $display("FAIL sat_reach: corr=%h expected ff", corr_cnt_o);
      end
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 32'h6A00_0000 + i, 2'b01, 7'h11);
         step();
      end
      drive(1'b0, '0, 2'b00, 7'h0);
      step();
      checks++;
      if (corr_cnt_o !== 8'hFF || uncorr_cnt_o !== 8'h00) begin
         errors++;
         $display("FAIL sat_hold: corr=%h uncorr=%h expected ff 00", corr_cnt_o, uncorr_cnt_o);
      end
   endtask

`ifdef PRIM_SECDED_SCRUB_EN
   task automatic test_scrub();
      out_ready_i = 1'b1;
      scrub_ack_i = 1'b1;
      step();
      scrub_ack_i = 1'b0;
      checks++;
      if (scrub_req_o !== 1'b0) begin
         errors++;
         $display("FAIL scrub_ack_clear: req=%b expected 0", scrub_req_o);
      end
      drive(1'b1, 32'hDEAD_BEEF, 2'b01, 7'h09);
      step();
      drive(1'b0, '0, 2'b00, 7'h0);
      checks++;
      if (scrub_req_o !== 1'b1 || scrub_data_o !== 32'hDEAD_BEEF) begin
         errors++;
         $display("FAIL scrub_set: req=%b data=%h expected 1 deadbeef", scrub_req_o, scrub_data_o);
      end
      repeat (3) step();
      drive(1'b1, 32'h1111_1111, 2'b01, 7'h09);
      step();
      drive(1'b0, '0, 2'b00, 7'h0);
      checks++;
      if (scrub_req_o !== 1'b1 || scrub_data_o !== 32'hDEAD_BEEF) begin
         errors++;
         $display("FAIL scrub_hold: req=%b data=%h expected 1 deadbeef", scrub_req_o, scrub_data_o);
      end
      scrub_ack_i = 1'b1;
      step();
      scrub_ack_i = 1'b0;
      checks++;
      if (scrub_req_o !== 1'b0) begin
         errors++;
         $display("FAIL scrub_ack: req=%b expected 0", scrub_req_o);
      end
   endtask
`endif

   task automatic test_drain();
      drive(1'b0, '0, 2'b00, 7'h0);
      out_ready_i = 1'b1;
      repeat (3) step();
      checks++;
      if (sb.size() != 0 || out_valid_o !== 1'b0) begin
         errors++;
         $display("FAIL drain: %0d responses outstanding, valid=%b, expected 0 and 0", sb.size(), out_valid_o);
      end
   endtask

   initial begin
      test_reset();
      test_reset_midflight();
      test_stream();
      test_backpressure();
      test_uncorr();
      test_clear();
      test_saturate();
`ifdef PRIM_SECDED_SCRUB_EN
      test_scrub();
`endif
      test_drain();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
